load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: takes load/store requests from the datapath and drives the word-wide data memory (address, write data, MemRead, MemWrite).
- Handles byte, half-word and word access with sign/zero extension on loads.
- Sub-word stores use read-modify-write.
- Sits between the CPU execute/mem stage and the data memory.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads with sign/zero extension, sub-word stores by read-modify-write.
// Define MISALIGN_TRAP_EN to add resp_err and reject misaligned half/word accesses without touching memory.

module lsu_byte_lane #(
  parameter int LANE_W = 8
) (
  input  logic              en,
  input  logic [LANE_W-1:0] old_byte,
  input  logic [LANE_W-1:0] new_byte,
  output logic [LANE_W-1:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic              resp_err,
`endif
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              MemRead,
  output logic              MemWrite
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  state_t           state;
  req_t             cur;
  logic [CNT_W-1:0] rd_cnt;

  logic accept, req_word, trap;
  assign accept   = req_valid && req_ready;
  assign req_word = req_size[1];

`ifdef MISALIGN_TRAP_EN
  assign trap = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Store merge: replicate the store data across lanes, then let the enable mask pick the target lane(s).
  logic [NUM_LANES-1:0]             byte_en;
  logic [NUM_LANES-1:0][LANE_W-1:0] wd_rep, rd_lanes, merged;

  always_comb begin
    byte_en = '1;
    wd_rep  = cur.wdata;
    case (cur.size)
      2'b00: begin
        byte_en = 4'b0001 << cur.lane;
        wd_rep  = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        byte_en = cur.lane[1] ? 4'b1100 : 4'b0011;
        wd_rep  = {2{cur.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_lanes = mem_rdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_byte_lane #(.LANE_W(LANE_W)) u_lane (
      .en       (byte_en[g]),
      .old_byte (rd_lanes[g]),
      .new_byte (wd_rep[g]),
      .merged   (merged[g])
    );
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  always_comb begin
    ld_b = rd_lanes[cur.lane];
    ld_h = cur.lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cur.size)
      2'b00:   ld_val = {{24{cur.sgn & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{cur.sgn & ld_h[15]}}, ld_h};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      rd_cnt     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      resp_err   <= 1'b0;
`endif
      case (state)
        // RESP also accepts, so a request held during the response starts without a bubble.
        IDLE, RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          if (accept) begin
            cur    <= '{we: req_we, size: req_size, sgn: req_signed,
                        lane: req_addr[1:0], wdata: req_wdata};
            rd_cnt <= '0;
            if (trap) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
              resp_err   <= 1'b1;
`endif
            end else begin
              req_ready <= 1'b0;
              mem_addr  <= 32'(req_addr >> 2);
              if (req_we && req_word) begin
                state     <= WR;
                MemWrite  <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state   <= RD;
                MemRead <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (rd_cnt == CNT_W'(RD_LAT - 1)) begin
            MemRead <= 1'b0;
            if (cur.we) begin
              state     <= WR;
              MemWrite  <= 1'b1;
              mem_wdata <= merged;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= ld_val;
              req_ready  <= 1'b1;
            end
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        WR: begin
          MemWrite   <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(MemRead && MemWrite));

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, back-to-back and reset sequences, RD_LAT=3 instance,
// and random traffic checked against a byte-array memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // RD_LAT=1 instance
  logic        req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, MemRead, MemWrite, resp_err_w;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  // RD_LAT=3 instance
  logic        s_valid = 0, s_ready, s_we = 0, s_signed = 0;
  logic [1:0]  s_size = 0;
  logic [31:0] s_addr = 0, s_wdata = 0;
  logic        s_resp_valid, s_MemRead, s_MemWrite, s_err_w;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;

`ifdef MISALIGN_TRAP_EN
  logic resp_err, s_err;
  assign resp_err_w = resp_err;
  assign s_err_w    = s_err;
`else
  assign resp_err_w = 1'b0;
  assign s_err_w    = 1'b0;
`endif

  load_store_unit #(.RD_LAT(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
`ifdef MISALIGN_TRAP_EN
    .resp_err(resp_err),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite));

  load_store_unit #(.RD_LAT(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_ready), .req_we(s_we),
    .req_size(s_size), .req_signed(s_signed), .req_addr(s_addr), .req_wdata(s_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_rdata),
`ifdef MISALIGN_TRAP_EN
    .resp_err(s_err),
`endif
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
    .MemRead(s_MemRead), .MemWrite(s_MemWrite));

  // Memories attached to the DUTs; preload goes through the same write process.
  logic [31:0] mem0 [0:63];
  logic [31:0] mem3 [0:63];
  logic        pre_we = 0;
  logic [5:0]  pre_idx = 0;
  logic [31:0] pre_dat = 0;

  assign mem_rdata   = mem0[mem_addr[5:0]];
  assign s_mem_rdata = mem3[s_mem_addr[5:0]];

  always @(posedge clk) begin
    if (MemWrite)    mem0[mem_addr[5:0]] <= mem_wdata;
    else if (pre_we) mem0[pre_idx] <= pre_dat;
    if (s_MemWrite)  mem3[s_mem_addr[5:0]] <= s_mem_wdata;
    else if (pre_we) mem3[pre_idx] <= pre_dat;
  end

  // Reference model: plain byte-addressed memory
  logic [7:0] ref_b [0:255];

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n, base;
    longint v;
    n = size_bytes(sz);
    base = (int'(a[7:0]) / n) * n;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_b[base + i]) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n, base;
    n = size_bytes(sz);
    base = (int'(a[7:0]) / n) * n;
    for (int i = 0; i < n; i++) ref_b[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] dat);
    pre_we = 1'b1; pre_idx = 6'(idx); pre_dat = dat;
    @(negedge clk);
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[idx * 4 + i] = 8'((dat >> (8 * i)) & 32'hFF);
  endtask

  // Issue one request on the RD_LAT=1 unit; called at a negedge with the unit ready.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
      input logic [31:0] wd, output logic [31:0] rd, output int lat, output int nrd, output int nwr,
      output logic both, output logic [31:0] wa, output logic [31:0] wdv, output logic er);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    rd = 32'hDEADBEEF; lat = 0; nrd = 0; nwr = 0; both = 0; wa = 0; wdv = 0; er = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; wa = mem_addr; wdv = mem_wdata; end
      if (MemRead && MemWrite) both = 1'b1;
      if (resp_valid) begin rd = resp_rdata; er = resp_err_w; break; end
    end
  endtask

  task automatic run3(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
      input logic [31:0] wd, output logic [31:0] rd, output int lat, output int nrd, output int nwr,
      output logic [31:0] wdv);
    s_we = we; s_size = sz; s_signed = sg; s_addr = a; s_wdata = wd; s_valid = 1'b1;
    rd = 32'hDEADBEEF; lat = 0; nrd = 0; nwr = 0; wdv = 0;
    @(posedge clk);
    #1 s_valid = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (s_MemRead) nrd++;
      if (s_MemWrite) begin nwr++; wdv = s_mem_wdata; end
      if (s_resp_valid) begin rd = s_rdata; break; end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wd;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] rd, wa, wdv;
    int lat, nrd, nwr, cnt_w, cnt_r;
    logic both, er;

    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, 32'h0,        2, 0, 1, 32'h2, 32'h12345678};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        32'h12345678, 2, 1, 0, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'hE, 32'h0,        32'hFFFFFFFF, 2, 1, 0, 32'h0, 32'h0};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 32'hC, 32'h0,        32'h00000001, 2, 1, 0, 32'h0, 32'h0};
    vt[4]  = '{1'b0, 2'd0, 1'b1, 32'hF, 32'h0,        32'hFFFFFF80, 2, 1, 0, 32'h0, 32'h0};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 32'hE, 32'h0,        32'hFFFF80FF, 2, 1, 0, 32'h0, 32'h0};
    vt[6]  = '{1'b0, 2'd1, 1'b0, 32'hE, 32'h0,        32'h000080FF, 2, 1, 0, 32'h0, 32'h0};
    vt[7]  = '{1'b1, 2'd0, 1'b0, 32'h5, 32'h00000011, 32'h0,        3, 1, 1, 32'h1, 32'hAABB11DD};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'hAABB11DD, 2, 1, 0, 32'h0, 32'h0};
    vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h6, 32'h1234BEEF, 32'h0,        3, 1, 1, 32'h1, 32'hBEEF11DD};
    vt[10] = '{1'b0, 2'd0, 1'b1, 32'hD, 32'h0,        32'h0000007F, 2, 1, 0, 32'h0, 32'h0};
    vt[11] = '{1'b0, 2'd3, 1'b0, 32'h8, 32'h0,        32'h12345678, 2, 1, 0, 32'h0, 32'h0};

    // Preload under reset
    @(negedge clk);
    for (int w = 0; w < 64; w++) preload(w, $urandom);
    preload(3, 32'h80FF7F01);
    preload(1, 32'hAABBCCDD);

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_memrd_memwr", {30'd0, MemRead, MemWrite}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_req(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, rd, lat, nrd, nwr, both, wa, wdv, er);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_memread_cycles", i), 32'(nrd), 32'(vt[i].nrd));
      chk($sformatf("vec%0d_memwrite_cycles", i), 32'(nwr), 32'(vt[i].nwr));
      if (vt[i].nwr != 0) begin
        chk($sformatf("vec%0d_mem_addr", i), wa, vt[i].waddr);
        chk($sformatf("vec%0d_mem_wdata", i), wdv, vt[i].wd);
      end
      chk($sformatf("vec%0d_rd_wr_overlap", i), 32'(both), 32'd0);
      if (vt[i].we) ref_store(vt[i].size, vt[i].addr, vt[i].wdata);
    end

    // Back-to-back: second request held valid through the first
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h8; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h4;
    @(negedge clk);
    chk("b2b_busy_ready", 32'(req_ready), 32'd0);
    chk("b2b_c1_memread", 32'(MemRead), 32'd1);
    chk("b2b_c1_mem_addr", mem_addr, 32'd2);
    @(negedge clk);
    chk("b2b_resp1_valid", 32'(resp_valid), 32'd1);
    chk("b2b_resp1_rdata", resp_rdata, ref_load(2'd2, 1'b0, 32'h8));
    chk("b2b_resp1_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c3_memread", 32'(MemRead), 32'd1);
    chk("b2b_c3_mem_addr", mem_addr, 32'd1);
    @(negedge clk);
    chk("b2b_resp2_valid", 32'(resp_valid), 32'd1);
    chk("b2b_resp2_rdata", resp_rdata, ref_load(2'd2, 1'b0, 32'h4));

    // Reset during RD of a sub-word store
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h5; req_wdata = 32'h5A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_memread_before", 32'(MemRead), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_memread_async", 32'(MemRead), 32'd0);
    chk("rstmid_memwrite_async", 32'(MemWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_w = 0; cnt_r = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (MemWrite) cnt_w++;
      if (resp_valid) cnt_r++;
    end
    chk("rstmid_no_memwrite", 32'(cnt_w), 32'd0);
    chk("rstmid_no_resp", 32'(cnt_r), 32'd0);
    chk("rstmid_mem_unchanged", mem0[1], ref_load(2'd2, 1'b0, 32'h4));

    // RD_LAT=3 instance: byte merge then readback
    run3(1'b1, 2'd0, 1'b0, 32'h5, 32'h11, rd, lat, nrd, nwr, wdv);
    chk("lat3_store_latency", 32'(lat), 32'd5);
    chk("lat3_store_memread_cycles", 32'(nrd), 32'd3);
    chk("lat3_store_memwrite_cycles", 32'(nwr), 32'd1);
    chk("lat3_store_mem_wdata", wdv, 32'hAABB11DD);
    chk("lat3_store_mem_word", mem3[1], 32'hAABB11DD);
    run3(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, rd, lat, nrd, nwr, wdv);
    chk("lat3_load_latency", 32'(lat), 32'd4);
    chk("lat3_load_rdata", rd, 32'h00000011);

`ifdef MISALIGN_TRAP_EN
    run_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, lat, nrd, nwr, both, wa, wdv, er);
    chk("trap_latency", 32'(lat), 32'd1);
    chk("trap_err", 32'(er), 32'd1);
    chk("trap_rdata", rd, 32'd0);
    chk("trap_no_memread", 32'(nrd), 32'd0);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, lat, nrd, nwr, both, wa, wdv, er);
    chk("aligned_err", 32'(er), 32'd0);
    chk("aligned_rdata", rd, ref_load(2'd2, 1'b0, 32'h4));
`else
    run_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, lat, nrd, nwr, both, wa, wdv, er);
    chk("misalign_word_rdata", rd, ref_load(2'd2, 1'b0, 32'h4));
    chk("misalign_word_latency", 32'(lat), 32'd2);
    run_req(1'b0, 2'd1, 1'b0, 32'h7, 32'h0, rd, lat, nrd, nwr, both, wa, wdv, er);
    chk("misalign_half_rdata", rd, ref_load(2'd1, 1'b0, 32'h6));
`endif

    // Random traffic against the byte-array model
    for (int i = 0; i < 300; i++) begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp;
      int          n, exp_lat;
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      n  = size_bytes(sz);
`ifdef MISALIGN_TRAP_EN
      a  = (a / 32'(n)) * 32'(n);
`endif
      exp     = we ? 32'd0 : ref_load(sz, sg, a);
      exp_lat = we ? ((n == 4) ? 2 : 3) : 2;
      run_req(we, sz, sg, a, wd, rd, lat, nrd, nwr, both, wa, wdv, er);
      chk($sformatf("rnd%0d_rdata we=%0d sz=%0d a=%h", i, we, sz, a), rd, exp);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_rd_wr_overlap", i), 32'(both), 32'd0);
`ifdef MISALIGN_TRAP_EN
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'd0);
`endif
      if (we) ref_store(sz, a, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
